// File: rtl/alu_sequencer_pkg.sv
// Shared opcodes, instruction field positions and FSM state encoding for alu_sequencer.
package alu_sequencer_pkg;

    localparam logic [5:0] OP_ADD   = 6'd0;
    localparam logic [5:0] OP_SUB   = 6'd1;
    localparam logic [5:0] OP_SHL   = 6'd2;
    localparam logic [5:0] OP_SHR   = 6'd3;
    localparam logic [5:0] OP_MOV   = 6'd4;
    localparam logic [5:0] OP_LOAD  = 6'd5;
    localparam logic [5:0] OP_CMPEQ = 6'd8;
    localparam logic [5:0] OP_CMPLT = 6'd9;
    localparam logic [5:0] OP_CMPGT = 6'd10;
    localparam logic [5:0] OP_JMP   = 6'd14;
    localparam logic [5:0] OP_JCC   = 6'd15;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;
    localparam int RA_MSB  = 25;
    localparam int RA_LSB  = 23;
    localparam int RB_MSB  = 22;
    localparam int RB_LSB  = 20;
    localparam int HL_BIT  = 19;
    localparam int VAL_MSB = 15;
    localparam int VAL_LSB = 0;

    localparam logic [2:0] REG_BRANCH = 3'd7;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_HALT   = 3'd4
    } seq_state_e;

    function automatic logic is_reg_write(input logic [5:0] op);
        return op < 6'd8;
    endfunction

    function automatic logic is_flag_write(input logic [5:0] op);
        return (op >= 6'd8) && (op <= 6'd13);
    endfunction

    // Only opcodes below 16 may redirect the PC; everything above is a NOP.
    function automatic logic may_branch(input logic [5:0] op);
        return op < 6'd16;
    endfunction

endpackage

// File: rtl/seq_regfile.sv
// 8x32 register file: two addressed read ports, a fixed branch-target read port, one sync write port.
module seq_regfile
    import alu_sequencer_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        we_i,
    input  logic [2:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [2:0]  ra_addr_i,
    input  logic [2:0]  rb_addr_i,
    output logic [31:0] ra_data_o,
    output logic [31:0] rb_data_o,
    output logic [31:0] r7_data_o
);

    logic [31:0] mem_q [8];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign ra_data_o = mem_q[ra_addr_i];
    assign rb_data_o = mem_q[rb_addr_i];
    assign r7_data_o = mem_q[REG_BRANCH];

endmodule

// File: rtl/alu_sequencer.sv
// Fetch/decode/execute/writeback sequencer feeding a combinational ALU.
// Optional retire port enabled by defining ALU_SEQUENCER_RETIRE_EN.
//
//   state  | meaning
//   FETCH  | request imem at pc, latch IR when imem_valid
//   DECODE | register ALU controls and operands from IR/regfile
//   EXEC   | ALU inputs held, sample ALU results
//   WB     | write rd or flags, advance/redirect pc
//   HALT   | frozen until reset
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [5:0]  HALT_OPCODE = 6'd63
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_data,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [31:0] alu_reg8,
    output logic [15:0] alu_value,
    output logic        alu_highlow,
    output logic        alu_f1,
    output logic        alu_f2,
    output logic [5:0]  alu_instr,
    input  logic [31:0] alu_c,
    input  logic        alu_flag,
    input  logic        alu_addrch,
    input  logic [31:0] alu_naddr,
`ifdef ALU_SEQUENCER_RETIRE_EN
    output logic        retire_valid,
    output logic [31:0] retire_pc,
`endif
    output logic        halted
);

    seq_state_e  state_q, state_d;
    logic [31:0] pc_q, ir_q;
    logic        f1_q, f2_q;
    logic [31:0] alu_a_q, alu_b_q, alu_reg8_q;
    logic [15:0] alu_value_q;
    logic        alu_highlow_q, alu_f1_q, alu_f2_q;
    logic [5:0]  alu_instr_q;
    logic [31:0] c_q, naddr_q;
    logic        flag_q, addrch_q;
    logic [31:0] rf_a, rf_b, rf_r7;
    logic        rf_we;
    logic [5:0]  opcode;
    logic        unused_ir;

    assign opcode    = ir_q[OPC_MSB:OPC_LSB];
    assign unused_ir = ^ir_q[18:16];
    assign rf_we     = (state_q == S_WB) && is_reg_write(opcode);

    seq_regfile u_regfile (
        .clock     (clock),
        .reset     (reset),
        .we_i      (rf_we),
        .waddr_i   (ir_q[RA_MSB:RA_LSB]),
        .wdata_i   (c_q),
        .ra_addr_i (ir_q[RA_MSB:RA_LSB]),
        .rb_addr_i (ir_q[RB_MSB:RB_LSB]),
        .ra_data_o (rf_a),
        .rb_data_o (rf_b),
        .r7_data_o (rf_r7)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Request and halt indication are masked during the reset cycle itself.
    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        halted   = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req = !reset;
                if (imem_valid) state_d = S_DECODE;
            end
            S_DECODE: state_d = (opcode == HALT_OPCODE) ? S_HALT : S_EXEC;
            S_EXEC:   state_d = S_WB;
            S_WB:     state_d = S_FETCH;
            S_HALT:   halted = !reset;
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            ir_q          <= '0;
            f1_q          <= 1'b0;
            f2_q          <= 1'b0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_reg8_q    <= '0;
            alu_value_q   <= '0;
            alu_highlow_q <= 1'b0;
            alu_f1_q      <= 1'b0;
            alu_f2_q      <= 1'b0;
            alu_instr_q   <= '0;
            c_q           <= '0;
            flag_q        <= 1'b0;
            addrch_q      <= 1'b0;
            naddr_q       <= '0;
        end else begin
            case (state_q)
                S_FETCH: if (imem_valid) ir_q <= imem_data;
                S_DECODE: begin
                    alu_a_q       <= rf_a;
                    alu_b_q       <= rf_b;
                    alu_reg8_q    <= rf_r7;
                    alu_value_q   <= ir_q[VAL_MSB:VAL_LSB];
                    alu_highlow_q <= ir_q[HL_BIT];
                    alu_instr_q   <= opcode;
                    alu_f1_q      <= f1_q;
                    alu_f2_q      <= f2_q;
                end
                S_EXEC: begin
                    c_q      <= alu_c;
                    flag_q   <= alu_flag;
                    addrch_q <= alu_addrch;
                    naddr_q  <= alu_naddr;
                end
                S_WB: begin
                    if (is_flag_write(opcode)) begin
                        f2_q <= f1_q;
                        f1_q <= flag_q;
                    end
                    if (addrch_q && may_branch(opcode)) pc_q <= naddr_q;
                    else                                pc_q <= pc_q + 32'd1;
                end
                default: ;
            endcase
        end
    end

    assign imem_addr   = pc_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_reg8    = alu_reg8_q;
    assign alu_value   = alu_value_q;
    assign alu_highlow = alu_highlow_q;
    assign alu_f1      = alu_f1_q;
    assign alu_f2      = alu_f2_q;
    assign alu_instr   = alu_instr_q;

`ifdef ALU_SEQUENCER_RETIRE_EN
    logic        retire_valid_q;
    logic [31:0] retire_pc_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            retire_valid_q <= 1'b0;
            retire_pc_q    <= '0;
        end else begin
            retire_valid_q <= (state_q == S_WB);
            if (state_q == S_WB) retire_pc_q <= pc_q;
        end
    end

    assign retire_valid = retire_valid_q;
    assign retire_pc    = retire_pc_q;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer with a hand-driven ALU.
module tb_alu_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_data  = '0;
    logic [31:0] alu_a, alu_b, alu_reg8;
    logic [15:0] alu_value;
    logic        alu_highlow, alu_f1, alu_f2;
    logic [5:0]  alu_instr;
    logic [31:0] alu_c      = '0;
    logic        alu_flag   = 1'b0;
    logic        alu_addrch = 1'b0;
    logic [31:0] alu_naddr  = '0;
    logic        halted;

    int checks   = 0;
    int failures = 0;

    // Snapshot of ALU controls taken during EXEC, plus imem_req across DECODE/EXEC/WB/FETCH.
    logic [31:0] obs_a, obs_b, obs_reg8;
    logic [15:0] obs_value;
    logic        obs_hl, obs_f1, obs_f2;
    logic [5:0]  obs_instr;
    logic [3:0]  req_trace;
    logic        stable;

    alu_sequencer dut (
        .clock       (clock),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_valid  (imem_valid),
        .imem_data   (imem_data),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_reg8    (alu_reg8),
        .alu_value   (alu_value),
        .alu_highlow (alu_highlow),
        .alu_f1      (alu_f1),
        .alu_f2      (alu_f2),
        .alu_instr   (alu_instr),
        .alu_c       (alu_c),
        .alu_flag    (alu_flag),
        .alu_addrch  (alu_addrch),
        .alu_naddr   (alu_naddr),
        .halted      (halted)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Runs one instruction from FETCH with imem_valid in the request cycle; returns in the next FETCH.
    task automatic run_instr(input logic [31:0] instr, input logic [31:0] c, input logic flag,
                             input logic addrch, input logic [31:0] naddr);
        alu_c      = c;
        alu_flag   = flag;
        alu_addrch = addrch;
        alu_naddr  = naddr;
        imem_valid = 1'b1;
        imem_data  = instr;
        tick();
        imem_valid   = 1'b0;
        imem_data    = 32'hA5A5_A5A5;
        req_trace[3] = imem_req;
        tick();
        req_trace[2] = imem_req;
        obs_a     = alu_a;
        obs_b     = alu_b;
        obs_reg8  = alu_reg8;
        obs_value = alu_value;
        obs_hl    = alu_highlow;
        obs_f1    = alu_f1;
        obs_f2    = alu_f2;
        obs_instr = alu_instr;
        tick();
        req_trace[1] = imem_req;
        tick();
        req_trace[0] = imem_req;
    endtask

    initial begin
        // Reset cycle: outputs cleared, request masked.
        tick();
        chk("rst_req",    32'(imem_req),  32'd0);
        chk("rst_halted", 32'(halted),    32'd0);
        chk("rst_instr",  32'(alu_instr), 32'd0);
        chk("rst_a",      alu_a,          32'd0);
        reset = 1'b0;
        #1;
        chk("first_req",  32'(imem_req), 32'd1);
        chk("first_addr", imem_addr,     32'd0);

        // LOAD r2, 0x1234
        run_instr(32'h1500_1234, 32'h0000_1234, 1'b0, 1'b0, 32'h0);
        chk("ld_instr", 32'(obs_instr), 32'd5);
        chk("ld_value", 32'(obs_value), 32'h1234);
        chk("ld_hl",    32'(obs_hl),    32'd0);
        chk("ld_trace", 32'(req_trace), 32'b0001);
        chk("ld_pc",    imem_addr,      32'd1);

        // Stall in FETCH for 5 cycles.
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (imem_req !== 1'b1 || imem_addr !== 32'd1 || alu_instr !== 6'd5) stable = 1'b0;
        end
        chk("stall_stable", 32'(stable), 32'd1);

        // MOV r3 <- (ra=3, rb=2, highlow=1, value=BEEF); rb reads fresh r2.
        run_instr(32'h11A8_BEEF, 32'hBEEF_0000, 1'b0, 1'b0, 32'h0);
        chk("mov_b_r2", obs_b,          32'h0000_1234);
        chk("mov_a_r3", obs_a,          32'd0);
        chk("mov_hl",   32'(obs_hl),    32'd1);
        chk("mov_val",  32'(obs_value), 32'hBEEF);
        chk("mov_pc",   imem_addr,      32'd2);

        // CMPEQ r3,r2 with flag=1.
        run_instr(32'h21A0_0000, 32'h0000_DEAD, 1'b1, 1'b0, 32'h0);
        chk("cmp_a_r3", obs_a,       32'hBEEF_0000);
        chk("cmp_f1",   32'(obs_f1), 32'd0);

        // JMP 0x40; f1 from the compare visible now.
        run_instr(32'h3800_0000, 32'h0000_5555, 1'b0, 1'b1, 32'h40);
        chk("jmp_f1",  32'(obs_f1), 32'd1);
        chk("jmp_f2",  32'(obs_f2), 32'd0);
        chk("jmp_pc",  imem_addr,   32'h40);

        // ADD r7 <- FFFFFFFF, then JCC to FFFFFFFF observing the new branch register.
        run_instr(32'h0380_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0);
        chk("add7_reg8", obs_reg8,  32'd0);
        chk("add7_pc",   imem_addr, 32'h41);
        run_instr(32'h3C00_0000, 32'h0000_0001, 1'b0, 1'b1, 32'hFFFF_FFFF);
        chk("jcc_reg8", obs_reg8,  32'hFFFF_FFFF);
        chk("jcc_r0",   obs_a,     32'd0);
        chk("jcc_pc",   imem_addr, 32'hFFFF_FFFF);

        // NOP (opcode 20, rd=1) at the top of the address space wraps to 0.
        run_instr(32'h5080_0000, 32'h1234_5678, 1'b1, 1'b0, 32'h0);
        chk("nop_wrap", imem_addr, 32'd0);

        // CMPLT r1,r0: r1 untouched by NOP, flags untouched by NOP.
        run_instr(32'h2480_0000, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("cmplt_r1", obs_a,       32'd0);
        chk("cmplt_f1", 32'(obs_f1), 32'd1);
        chk("cmplt_f2", 32'(obs_f2), 32'd0);

        // ADD r2,r2 (ra==rb); flags shifted by the previous compare.
        run_instr(32'h0120_0000, 32'h0000_2468, 1'b0, 1'b0, 32'h0);
        chk("same_a",  obs_a,       32'h0000_1234);
        chk("same_b",  obs_b,       32'h0000_1234);
        chk("same_f1", 32'(obs_f1), 32'd0);
        chk("same_f2", 32'(obs_f2), 32'd1);
        chk("same_pc", imem_addr,   32'd2);

        // HALT.
        imem_valid = 1'b1;
        imem_data  = 32'hFC00_0000;
        tick();
        imem_valid = 1'b0;
        tick();
        chk("halt_flag",  32'(halted),    32'd1);
        chk("halt_req",   32'(imem_req),  32'd0);
        chk("halt_instr", 32'(alu_instr), 32'd63);
        imem_valid = 1'b1;
        stable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (halted !== 1'b1 || imem_req !== 1'b0 || imem_addr !== 32'd2) stable = 1'b0;
        end
        imem_valid = 1'b0;
        chk("halt_hold", 32'(stable), 32'd1);

        // One-cycle reset out of HALT.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("rst2_req",    32'(imem_req), 32'd1);
        chk("rst2_addr",   imem_addr,     32'd0);
        chk("rst2_halted", 32'(halted),   32'd0);
        run_instr(32'h1170_0000, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("rst2_f1",   32'(obs_f1), 32'd0);
        chk("rst2_f2",   32'(obs_f2), 32'd0);
        chk("rst2_r2",   obs_a,       32'd0);
        chk("rst2_reg8", obs_reg8,    32'd0);

        // Reset during EXEC of ADD r4: no writeback, fetch restarts at 0.
        imem_valid = 1'b1;
        imem_data  = 32'h0200_0000;
        alu_c      = 32'h0000_0077;
        alu_addrch = 1'b0;
        tick();
        imem_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("mid_addr", imem_addr,     32'd0);
        chk("mid_req",  32'(imem_req), 32'd1);
        run_instr(32'h1200_0000, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("mid_r4", obs_a, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Control-side counterpart to the ALU: fetches 32-bit instruction words, decodes them into ALU controls (instr, value, highlow, A/B operands, reg8, F1/F2), then consumes the ALU results (C, F3, addrch, naddr).
- Owns the 8×32 register file, the two flag bits and the PC.
- Sits between instruction memory and the ALU. Multi-cycle, one instruction in flight.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- HALT_OPCODE, 6'd63, opcode that stops the sequencer until reset.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request; held high until imem_valid is seen.
- imem_addr  out  32  fetch address (= PC); stable while imem_req is high.
- imem_valid  in  1  instruction word present on imem_data this cycle.
- imem_data  in  32  instruction word.
- alu_a, alu_b  out  32  operands: regfile[ra], regfile[rb].
- alu_reg8  out  32  regfile[7], the branch-target register.
- alu_value  out  16  immediate.
- alu_highlow  out  1  immediate half select.
- alu_f1, alu_f2  out  1  flag register bits.
- alu_instr  out  6  opcode.
- alu_c  in  32  ALU result.
- alu_flag  in  1  ALU condition output (F3).
- alu_addrch  in  1  ALU branch-taken.
- alu_naddr  in  32  ALU branch target.
- halted  out  1  high while in HALT.

Behaviour:
- Instruction format:
  - [31:26] opcode
  - [25:23] ra/rd
  - [22:20] rb
  - [19] highlow
  - [18:16] reserved, ignored
  - [15:0] value
- FSM states: FETCH, DECODE, EXEC, WB, HALT. Reset enters FETCH.
- FETCH:
  - imem_req=1 and imem_addr=pc.
  - On imem_valid, latch imem_data into the IR, drop imem_req the next cycle, go to DECODE.
  - Unbounded wait; no timeout.
- DECODE:
  - Register alu_a/alu_b/alu_reg8 from the regfile, and alu_instr/alu_value/alu_highlow from the IR.
  - If the opcode is HALT_OPCODE, go to HALT; otherwise go to EXEC.
- EXEC:
  - ALU inputs are held stable.
  - The ALU is combinational. Sample alu_c, alu_flag, alu_addrch and alu_naddr into holding registers at the end of this cycle.
- WB:
  - Opcodes 0–7: regfile[rd] <= sampled C.
  - Opcodes 8–13: f2 <= f1, then f1 <= sampled flag.
  - PC update: if sampled addrch is set, pc <= sampled naddr; otherwise pc <= pc+1.
  - Go to FETCH.
  - Opcodes 16–62 are NOPs: no register or flag write, pc+1.
- Latency: 4 cycles per instruction when imem_valid is returned in the same cycle as the request.
- Outputs change only while in DECODE. They hold their values through EXEC and WB.
- PC wraps from 32'hFFFF_FFFF to 0 with no flag.
- r0 is an ordinary writable register. A write to r7 updates alu_reg8 from the next DECODE onward.
- ra==rb is legal: both operands read the same register.
- Writeback to rd and use of the same register by the next instruction: the next instruction sees the new value, because WB precedes DECODE.
- imem_valid outside FETCH is ignored.
- HALT:
  - halted=1, imem_req=0, no state changes.
  - Exit only through reset.
- Reset values:
  - pc=RESET_PC, regfile all 0, f1=f2=0, IR=0.
  - All ALU-control outputs 0, imem_req=0 in the reset cycle, halted=0.
- Reset mid-fetch or mid-instruction: the instruction is discarded, no writeback occurs, and FETCH restarts at RESET_PC on the first cycle after reset deasserts.

Optional Feature:
- ALU_SEQUENCER_RETIRE_EN.
- Defined:
  - Adds output ports retire_valid (1) and retire_pc (32).
  - retire_valid pulses for exactly one cycle, in the cycle after each WB.
  - retire_pc carries the address of the retired instruction.
  - HALT does not retire.
- Undefined: the ports are absent and there is no retire logic.

Decomposition:
- Shared package contents:
  - opcode constants: OP_ADD=0, OP_SUB=1, OP_SHL=2, OP_SHR=3, OP_MOV=4, OP_LOAD=5, OP_CMPEQ=8, OP_CMPLT=9, OP_CMPGT=10, OP_JMP=14, OP_JCC=15
  - FSM state enum
  - instruction field bit positions
  - REG_BRANCH=7
- One natural sub-module: seq_regfile. It has 8×32 entries, 3 read ports (a, b, fixed r7) and 1 synchronous write port, with reset clearing all entries.

Test Plan:
- Reset, then an immediate fetch → imem_req=1 and imem_addr=0 on the first cycle after reset.
- Instruction with opcode 5, rd=2, highlow=0, value=16'h1234, with ALU model returning 32'h0000_1234 → r2=32'h0000_1234, pc=1, and 4 cycles from request to next request.
- Hold imem_valid low for 5 cycles during FETCH → imem_req and imem_addr stay stable, and no state advances.
- Compare opcode 8 with alu_flag=1, then opcode 14 with alu_addrch=1 and alu_naddr=32'h40 → f1=1, next imem_addr=32'h40.
- PC=32'hFFFF_FFFF executing a NOP (opcode 20) → next imem_addr=0, and no register changes.
- Opcode 63 → halted=1 and no further requests. Asserting reset for 1 cycle then returns to FETCH at RESET_PC with f1=f2=0.
